// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the mini-MIPS core.
//
// Receives a byte stream over a valid/ready handshake, packs byte pairs into
// 16-bit instruction words (high byte first) and writes them to consecutive
// instruction-memory word addresses starting at 0. The CPU is held in reset
// (cpu_hold=1) until the whole image has been written.
//
// Stream: N[15:8], N[7:0], 2N payload bytes, then one checksum byte when the
// optional checksum check is built in.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   -> CHK state after FLUSH; 8-bit running sum of payload bytes is
//                compared against the trailing checksum byte.
//   undefined -> FLUSH goes straight to DONE; error only on a bad N.
//
// Ports:
//   clock        in   system clock, all state updates on posedge
//   reset        in   synchronous, active-high reset
//   in_valid     in   in_data holds a valid byte
//   in_data      in   stream byte
//   in_ready     out  loader can accept a byte this cycle
//   mem_we       out  instruction-memory write strobe, one cycle per word
//   mem_addr     out  word address of the write
//   mem_wdata    out  instruction word being written
//   cpu_hold     out  1 = CPU held, PC kept at 0
//   done         out  image fully loaded
//   error        out  bad header, or checksum mismatch when enabled
//   dbg_state_o  out  current FSM state (debug visibility)
//
// Handshake: a byte is transferred on a posedge where in_valid && in_ready.
// in_ready depends only on the FSM state (forced low while reset is held);
// the sender must keep in_data stable while in_valid=1 and in_ready=0.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [3:0]        dbg_state_o
);

  localparam int CW = ADDR_W + 1;
  // Largest legal word count, widened so N=0xFFFF compares correctly.
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [3:0] {
    S_CNT_HI = 4'd0,
    S_CNT_LO = 4'd1,
    S_CHKN   = 4'd2,
    S_W_HI   = 4'd3,
    S_W_LO   = 4'd4,
    S_FLUSH  = 4'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK    = 4'd6,
`endif
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        hold_q, hold_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [16:0]   cnt_inc_ext;

  assign accept      = in_valid && in_ready;
  assign cnt_inc     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
  assign cnt_inc_ext = 17'(cnt_inc);

  // in_ready is a pure state decode; reset masks it so no byte looks
  // accepted while the loader is being cleared.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                              in_ready = 1'b1;
`endif
      default:                            in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_CNT_HI: if (accept) begin
        n_d[15:8] = in_data;
        state_d   = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        n_d[7:0] = in_data;
        state_d  = S_CHKN;
      end
      S_CHKN: begin
        if (n_q == 16'd0 || {1'b0, n_q} > DEPTH) state_d = S_ERROR;
        else                                      state_d = S_W_HI;
      end
      S_W_HI: if (accept) begin
        hold_d  = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + in_data;
`endif
        state_d = S_W_LO;
      end
      S_W_LO: if (accept) begin
        wdata_d = {hold_q, in_data};
        addr_d  = cnt_q[ADDR_W-1:0];
        we_d    = 1'b1;
        cnt_d   = cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + in_data;
`endif
        state_d = (cnt_inc_ext == {1'b0, n_q}) ? S_FLUSH : S_W_HI;
      end
      // One idle cycle so the last write strobe never overlaps done.
      S_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = S_CHK;
`else
        state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_CNT_HI;
      n_q     <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign cpu_hold    = (state_q != S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of header/payload cases plus hand-written
// sequences for reset mid-load, stalls in non-ready states and checksum.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [3:0]        dbg_state_o;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int we_count = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [7:0] sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      logic [ADDR_W+DATA_W-1:0] e;
      we_count++;
      last_addr = mem_addr;
      check("we_not_with_done", {31'd0, done}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty queue", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {22'd0, mem_addr}, {22'd0, e[ADDR_W+DATA_W-1:DATA_W]});
        check("wr_data", {16'd0, mem_wdata}, {16'd0, e[DATA_W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int waited = 0;
    if (rnd) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    while (in_ready !== 1'b1 && waited < 40) begin
      waited++;
      @(negedge clock);
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"},  {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_error"},     {31'd0, error}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("rst");
    exp_q.delete();
    we_count = 0;
    sum = 8'h00;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] n;
    bit          fixed;    // use payload 80 10 81 04
    bit          rnd;      // random in_valid gaps
    bit          exp_err;
  } vec_t;

  vec_t vt[8];
  logic [7:0] fixed_pay[4];

  initial begin
    fixed_pay[0] = 8'h80; fixed_pay[1] = 8'h10;
    fixed_pay[2] = 8'h81; fixed_pay[3] = 8'h04;
    vt[0] = '{16'd2,    1'b1, 1'b0, 1'b0};
    vt[1] = '{16'd0,    1'b0, 1'b0, 1'b1};
    vt[2] = '{16'd1025, 1'b0, 1'b0, 1'b1};
    vt[3] = '{16'd1024, 1'b0, 1'b0, 1'b0};
    vt[4] = '{16'd2,    1'b1, 1'b1, 1'b0};
    vt[5] = '{16'd3,    1'b0, 1'b1, 1'b0};
    vt[6] = '{16'hFFFF, 1'b0, 1'b0, 1'b1};
    vt[7] = '{16'd1,    1'b0, 1'b1, 1'b0};

    for (int t = 0; t < 8; t++) begin
      do_reset();
      send_byte(vt[t].n[15:8], vt[t].rnd);
      send_byte(vt[t].n[7:0], vt[t].rnd);
      if (vt[t].exp_err) begin
        @(negedge clock);
        @(negedge clock);
        check("err_error",    {31'd0, error}, 32'd1);
        check("err_in_ready", {31'd0, in_ready}, 32'd0);
        check("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("err_done",     {31'd0, done}, 32'd0);
        // Bytes offered while not ready must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        check("err_sticky",   {31'd0, error}, 32'd1);
        check("err_no_write", we_count, 0);
      end else begin
        for (int w = 0; w < int'(vt[t].n); w++) begin
          logic [7:0] hi;
          logic [7:0] lo;
          if (vt[t].fixed) begin
            hi = fixed_pay[2*w];
            lo = fixed_pay[2*w+1];
          end else begin
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
          end
          sum = sum + hi + lo;
          send_byte(hi, vt[t].rnd);
          exp_q.push_back({10'(w), hi, lo});
          send_byte(lo, vt[t].rnd);
        end
        // cycle k+1: final write strobe, still held
        @(negedge clock);
        check("last_we",       {31'd0, mem_we}, 32'd1);
        check("last_done",     {31'd0, done}, 32'd0);
        check("flush_ready",   {31'd0, in_ready}, 32'd0);
        check("flush_hold",    {31'd0, cpu_hold}, 32'd1);
        @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("chk_done",      {31'd0, done}, 32'd0);
        check("chk_ready",     {31'd0, in_ready}, 32'd1);
        send_byte(sum, 1'b0);
        @(negedge clock);
`endif
        check("fin_done",      {31'd0, done}, 32'd1);
        check("fin_hold",      {31'd0, cpu_hold}, 32'd0);
        check("fin_we",        {31'd0, mem_we}, 32'd0);
        check("fin_ready",     {31'd0, in_ready}, 32'd0);
        check("fin_error",     {31'd0, error}, 32'd0);
        check("fin_we_count",  we_count, int'(vt[t].n));
        check("fin_q_empty",   exp_q.size(), 0);
        check("fin_last_addr", {22'd0, last_addr}, 32'(vt[t].n - 16'd1));
      end
    end

    // ---- reset mid-load, then a fresh single-word load ----
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    exp_q.push_back({10'd0, 16'h1122});
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("midrst");
    check("midrst_one_write", we_count, 1);
    check("midrst_q_empty", exp_q.size(), 0);
    reset = 1'b0;
    we_count = 0;
    sum = 8'h00;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    exp_q.push_back({10'd0, 16'h1020});
    send_byte(8'h20, 1'b0);
    @(negedge clock);
    @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h30, 1'b0);
    @(negedge clock);
`endif
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_writes", we_count, 1);
    check("reload_q_empty", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- wrong checksum byte ----
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 4; i += 2) begin
      send_byte(fixed_pay[i], 1'b0);
      exp_q.push_back({10'(i / 2), fixed_pay[i], fixed_pay[i+1]});
      send_byte(fixed_pay[i+1], 1'b0);
    end
    @(negedge clock);
    @(negedge clock);
    send_byte(8'h16, 1'b0);
    @(negedge clock);
    check("badsum_error", {31'd0, error}, 32'd1);
    check("badsum_hold",  {31'd0, cpu_hold}, 32'd1);
    check("badsum_done",  {31'd0, done}, 32'd0);
    check("badsum_writes", we_count, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
